// File: rtl/dmem_sbuf.sv
// Posted-write store buffer between the dtim controller and the data memory bus.
// Optional read forwarding/bypass from the FIFO is enabled by defining SBUF_FWD_EN.
module dmem_sbuf #(
  parameter int sbuf_depth = 2
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        sbuf_in_valid,
  input  logic        sbuf_in_fence,
  input  logic        sbuf_in_instr,
  input  logic [31:0] sbuf_in_addr,
  input  logic [31:0] sbuf_in_wdata,
  input  logic [3:0]  sbuf_in_wstrb,
  output logic [31:0] sbuf_out_rdata,
  output logic        sbuf_out_ready,
  input  logic [31:0] mem_out_rdata,
  input  logic        mem_out_ready,
  output logic        mem_in_valid,
  output logic        mem_in_fence,
  output logic        mem_in_instr,
  output logic [31:0] mem_in_addr,
  output logic [31:0] mem_in_wdata,
  output logic [3:0]  mem_in_wstrb
);

  localparam int depth_n = 1 << sbuf_depth;

  typedef logic [sbuf_depth-1:0] ptr_t;
  typedef logic [sbuf_depth:0]   cnt_t;

  localparam cnt_t full_cnt = cnt_t'(depth_n);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RDRAIN, S_READ, S_RESP, S_FDRAIN
  } state_t;

  state_t state, state_next;

  logic [31:0] fifo_addr  [depth_n];
  logic [31:0] fifo_wdata [depth_n];
  logic [3:0]  fifo_wstrb [depth_n];

  ptr_t wptr, rptr, rptr_next;
  cnt_t count, count_next;

  logic        txn_rd;
  logic        push, pop, done, rd_done, port_free, full, last_out;
  logic        issue_rd, drain_go;
  logic [31:0] resp_data;
  logic [31:0] head_addr, head_wdata;
  logic [3:0]  head_wstrb;

  logic unused;
  assign unused = sbuf_in_instr;

  assign mem_in_fence = 1'b0;
  assign mem_in_instr = 1'b0;

  // A ready with no transaction on the port does nothing.
  assign done       = mem_in_valid & mem_out_ready;
  assign pop        = done & ~txn_rd;
  assign rd_done    = done & txn_rd;
  assign port_free  = ~mem_in_valid | done;
  assign full       = (count == full_cnt);
  assign last_out   = (count == cnt_t'(pop));
  assign count_next = count + cnt_t'(push) - cnt_t'(pop);
  assign rptr_next  = rptr + ptr_t'(pop);

`ifdef SBUF_FWD_EN
  logic        fwd_hit, fwd_full;
  logic [31:0] fwd_data;
  ptr_t        fwd_idx;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_full = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < depth_n; k++) begin
      fwd_idx = rptr + ptr_t'(k);
      if (k < int'(count) && fifo_addr[fwd_idx][31:2] == sbuf_in_addr[31:2]) begin
        fwd_hit  = 1'b1;
        fwd_full = (fifo_wstrb[fwd_idx] == 4'hF);
        fwd_data = fifo_wdata[fwd_idx];
      end
    end
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    resp_data  = '0;
    case (state)
      S_IDLE: begin
        if (sbuf_in_valid) begin
          if (sbuf_in_fence) begin
            state_next = S_FDRAIN;
          end else if (|sbuf_in_wstrb) begin
            if (!full) begin
              push       = 1'b1;
              state_next = S_ACK;
            end
          end else begin
`ifdef SBUF_FWD_EN
            if (!fwd_hit) begin
              state_next = S_READ;
            end else if (fwd_full) begin
              state_next = S_ACK;
              resp_data  = fwd_data;
            end else begin
              state_next = S_RDRAIN;
            end
`else
            state_next = S_RDRAIN;
`endif
          end
        end
      end
      S_ACK:    state_next = S_IDLE;
      S_RDRAIN: if (last_out) state_next = S_READ;
      S_READ: begin
        if (rd_done) begin
          state_next = S_RESP;
          resp_data  = mem_out_rdata;
        end
      end
      S_RESP:   state_next = S_IDLE;
      S_FDRAIN: if (last_out) state_next = S_RESP;
      default:  state_next = S_IDLE;
    endcase
  end

  // When the FIFO empties this edge, the head is the entry being pushed now.
  always_comb begin
    if (last_out) begin
      head_addr  = sbuf_in_addr;
      head_wdata = sbuf_in_wdata;
      head_wstrb = sbuf_in_wstrb;
    end else begin
      head_addr  = fifo_addr[rptr_next];
      head_wdata = fifo_wdata[rptr_next];
      head_wstrb = fifo_wstrb[rptr_next];
    end
  end

  assign issue_rd = (state_next == S_READ) && port_free;
  assign drain_go = (state_next != S_READ) && (count_next != '0);

  // NOTE: entry storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr]  <= sbuf_in_addr;
      fifo_wdata[wptr] <= sbuf_in_wdata;
      fifo_wstrb[wptr] <= sbuf_in_wstrb;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      count          <= '0;
      wptr           <= '0;
      rptr           <= '0;
      txn_rd         <= 1'b0;
      sbuf_out_ready <= 1'b0;
      sbuf_out_rdata <= '0;
      mem_in_valid   <= 1'b0;
      mem_in_addr    <= '0;
      mem_in_wdata   <= '0;
      mem_in_wstrb   <= '0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      wptr           <= wptr + ptr_t'(push);
      rptr           <= rptr_next;
      sbuf_out_ready <= (state_next == S_ACK) || (state_next == S_RESP);
      sbuf_out_rdata <= resp_data;
      if (port_free) begin
        if (issue_rd) begin
          mem_in_valid <= 1'b1;
          txn_rd       <= 1'b1;
          mem_in_addr  <= sbuf_in_addr;
          mem_in_wdata <= '0;
          mem_in_wstrb <= '0;
        end else if (drain_go) begin
          mem_in_valid <= 1'b1;
          txn_rd       <= 1'b0;
          mem_in_addr  <= head_addr;
          mem_in_wdata <= head_wdata;
          mem_in_wstrb <= head_wstrb;
        end else begin
          mem_in_valid <= 1'b0;
          txn_rd       <= 1'b0;
          mem_in_addr  <= '0;
          mem_in_wdata <= '0;
          mem_in_wstrb <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_sbuf.sv
// Scoreboard bench for dmem_sbuf: expected responses and memory transactions are queued
// by the stimulus and checked by independent monitors.
module tb_dmem_sbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_fence, in_instr;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_wstrb;
  logic [31:0] sbuf_out_rdata;
  logic        sbuf_out_ready;
  logic [31:0] mem_out_rdata;
  logic        mem_out_ready;
  logic        mem_in_valid, mem_in_fence, mem_in_instr;
  logic [31:0] mem_in_addr, mem_in_wdata;
  logic [3:0]  mem_in_wstrb;

  dmem_sbuf #(.sbuf_depth(2)) dut (
    .rst(rst), .clk(clk),
    .sbuf_in_valid(in_valid), .sbuf_in_fence(in_fence), .sbuf_in_instr(in_instr),
    .sbuf_in_addr(in_addr), .sbuf_in_wdata(in_wdata), .sbuf_in_wstrb(in_wstrb),
    .sbuf_out_rdata(sbuf_out_rdata), .sbuf_out_ready(sbuf_out_ready),
    .mem_out_rdata(mem_out_rdata), .mem_out_ready(mem_out_ready),
    .mem_in_valid(mem_in_valid), .mem_in_fence(mem_in_fence), .mem_in_instr(mem_in_instr),
    .mem_in_addr(mem_in_addr), .mem_in_wdata(mem_in_wdata), .mem_in_wstrb(mem_in_wstrb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  txn_t        mem_exp[$];
  logic [31:0] resp_exp[$];
  int          ready_log[$];
  int          valid_log[$];
  int          mem_lat = 3;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] resp_e;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Memory responder: ready after mem_lat cycles of valid; checks every presented transaction.
  initial begin : responder
    int          wait_cnt;
    logic [31:0] cur;
    wait_cnt = 0;
    mem_out_ready = 1'b0;
    mem_out_rdata = '0;
    forever begin
      @(negedge clk);
      mem_out_ready = 1'b0;
      mem_out_rdata = '0;
      if (!rst && mem_in_valid) begin
        if (wait_cnt == 0) valid_log.push_back(cyc);
        wait_cnt++;
        if (mem_exp.size() == 0)
          fail_now("mem_unexpected", $sformatf("got addr %0h strb %0h, expected no transaction",
                                               mem_in_addr, mem_in_wstrb));
        else
          check("mem_txn", {mem_in_addr, mem_in_wdata, mem_in_wstrb}, mem_exp[0]);
        if (wait_cnt >= mem_lat) begin
          cur = mem_model.exists(mem_in_addr) ? mem_model[mem_in_addr] : (mem_in_addr ^ 32'h5A5A_0000);
          if (mem_in_wstrb == 4'h0) begin
            mem_out_rdata = cur;
          end else begin
            for (int b = 0; b < 4; b++)
              if (mem_in_wstrb[b]) cur[8*b +: 8] = mem_in_wdata[8*b +: 8];
            mem_model[mem_in_addr] = cur;
          end
          mem_out_ready = 1'b1;
          if (mem_exp.size() != 0) void'(mem_exp.pop_front());
          ready_log.push_back(cyc);
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && sbuf_out_ready) begin
      if (resp_exp.size() == 0) begin
        fail_now("resp_unexpected", $sformatf("got rdata %0h, expected no response", sbuf_out_rdata));
      end else begin
        resp_e = resp_exp.pop_front();
        check("resp_rdata", 68'(sbuf_out_rdata), 68'(resp_e));
      end
    end
  end

  task automatic exp_mem(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    txn_t t;
    t.addr = addr; t.wdata = wdata; t.strb = strb;
    mem_exp.push_back(t);
  endtask

  task automatic req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input logic fence, input logic [31:0] exp_rdata, input int exp_lat,
                     input string name, output int ack_cyc);
    int n;
    n = 0;
    resp_exp.push_back(exp_rdata);
    @(negedge clk);
    in_valid = 1'b1; in_fence = fence; in_addr = addr; in_wdata = wdata; in_wstrb = strb;
    do begin
      @(negedge clk);
      n++;
    end while (!sbuf_out_ready && n < 200);
    ack_cyc = cyc;
    if (!sbuf_out_ready) fail_now({name, "_timeout"}, "got no ready within 200 cycles, expected one");
    else if (exp_lat >= 0) check({name, "_lat"}, 68'(n), 68'(exp_lat));
    in_valid = 1'b0; in_fence = 1'b0; in_addr = '0; in_wdata = '0; in_wstrb = '0;
  endtask

  task automatic drain_wait(input string name);
    int n;
    n = 0;
    while ((mem_exp.size() != 0 || mem_in_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now({name, "_drain_timeout"}, "got busy memory port, expected drained");
    repeat (2) @(negedge clk);
    ready_log.delete();
    valid_log.delete();
  endtask

  initial begin
    int a0, a1, a2, a3, a4;
    rst = 1'b1;
    in_valid = 1'b0; in_fence = 1'b0; in_instr = 1'b0;
    in_addr = '0; in_wdata = '0; in_wstrb = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 68'({sbuf_out_ready, mem_in_valid, mem_in_fence, mem_in_instr}), 68'(0));
    check("rst_mem_fields", {mem_in_addr, mem_in_wdata, mem_in_wstrb}, 68'(0));
    check("rst_rdata", 68'(sbuf_out_rdata), 68'(0));
    check("rst_count", 68'(dut.count), 68'(0));
    rst = 1'b0;

    // Single write, memory ready after 3 cycles.
    mem_lat = 3;
    exp_mem(32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    req(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1, "wr1", a0);
    for (int n = 0; n < 50 && ready_log.size() == 0; n++) @(negedge clk);
    @(negedge clk);
    check("wr1_valid_after_ready", 68'(mem_in_valid), 68'(0));
    check("wr1_drain_start", 68'(valid_log[0]), 68'(a0));
    drain_wait("wr1");

    // Five back-to-back writes into a 4-entry FIFO, memory ready after 10 cycles.
    mem_lat = 10;
    exp_mem(32'h100, 32'hA0, 4'hF);
    exp_mem(32'h104, 32'hA1, 4'h3);
    exp_mem(32'h108, 32'hA2, 4'hF);
    exp_mem(32'h10C, 32'hA3, 4'hC);
    exp_mem(32'h110, 32'hA4, 4'hF);
    req(32'h100, 32'hA0, 4'hF, 1'b0, 32'h0, 1, "bb0", a0);
    req(32'h104, 32'hA1, 4'h3, 1'b0, 32'h0, 1, "bb1", a1);
    req(32'h108, 32'hA2, 4'hF, 1'b0, 32'h0, 1, "bb2", a2);
    req(32'h10C, 32'hA3, 4'hC, 1'b0, 32'h0, 1, "bb3", a3);
    req(32'h110, 32'hA4, 4'hF, 1'b0, 32'h0, -1, "bb4", a4);
    check("bb4_ack_after_pop", 68'(a4), 68'(ready_log[0] + 2));
    drain_wait("bb");

`ifdef SBUF_FWD_EN
    // Full-word forward plus miss bypass ahead of a buffered write.
    mem_lat = 10;
    exp_mem(32'h3000, 32'hCAFE_F00D, 4'hF);
    exp_mem(32'h3004, 32'h0, 4'h0);
    exp_mem(32'h3008, 32'h1234_5678, 4'hF);
    req(32'h3000, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1, "fw_w0", a0);
    req(32'h3008, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1, "fw_w1", a1);
    req(32'h3000, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1, "fw_hit", a2);
    req(32'h3004, 32'h0, 4'h0, 1'b0, 32'h5A5A_3004, -1, "fw_miss", a3);
    drain_wait("fw");
`else
    // Read after write: the read waits for the write to reach memory.
    mem_lat = 4;
    exp_mem(32'h2000, 32'h1122_3344, 4'hF);
    exp_mem(32'h2000, 32'h0, 4'h0);
    req(32'h2000, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1, "raw_w", a0);
    req(32'h2000, 32'h0, 4'h0, 1'b0, 32'h1122_3344, -1, "raw_r", a1);
    check("raw_read_after_write", 68'(valid_log[1] > ready_log[0]), 68'(1));
    drain_wait("raw");
    exp_mem(32'h2040, 32'h0, 4'h0);
    req(32'h2040, 32'h0, 4'h0, 1'b0, 32'h5A5A_2040, -1, "rd_cold", a0);
    drain_wait("rd_cold");
`endif

    // Fence behind three buffered writes.
    mem_lat = 8;
    exp_mem(32'h600, 32'h0000_0001, 4'hF);
    exp_mem(32'h604, 32'h0000_0002, 4'hF);
    exp_mem(32'h608, 32'h0000_0003, 4'h1);
    req(32'h600, 32'h1, 4'hF, 1'b0, 32'h0, 1, "fn_w0", a0);
    req(32'h604, 32'h2, 4'hF, 1'b0, 32'h0, 1, "fn_w1", a1);
    req(32'h608, 32'h3, 4'h1, 1'b0, 32'h0, 1, "fn_w2", a2);
    req(32'h0, 32'h0, 4'h0, 1'b1, 32'h0, -1, "fence", a3);
    check("fence_drained", 68'(ready_log.size()), 68'(3));
    if (ready_log.size() == 3) check("fence_lat", 68'(a3), 68'(ready_log[2] + 1));
    drain_wait("fence");

    // Reset mid-drain with two entries buffered.
    mem_lat = 10;
    exp_mem(32'h4000, 32'h4444_0000, 4'hF);
    exp_mem(32'h4004, 32'h4444_0004, 4'hF);
    req(32'h4000, 32'h4444_0000, 4'hF, 1'b0, 32'h0, 1, "rs_w0", a0);
    req(32'h4004, 32'h4444_0004, 4'hF, 1'b0, 32'h0, 1, "rs_w1", a1);
    check("rs_count_before", 68'(dut.count), 68'(2));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_exp.delete();
    check("rs_valid", 68'(mem_in_valid), 68'(0));
    check("rs_count", 68'(dut.count), 68'(0));
    check("rs_ready", 68'(sbuf_out_ready), 68'(0));
    mem_lat = 3;
    exp_mem(32'h5000, 32'h5555_AAAA, 4'hF);
    req(32'h5000, 32'h5555_AAAA, 4'hF, 1'b0, 32'h0, 1, "rs_after", a0);
    drain_wait("rs_after");

    check("resp_queue_empty", 68'(resp_exp.size()), 68'(0));
    check("mem_queue_empty", 68'(mem_exp.size()), 68'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_sbuf.md
# dmem_sbuf

Posted-write store buffer between the data TIM controller's backing-memory port (`dmem_in`/`dmem_out`) and the data memory bus. Writes are acknowledged from a small FIFO and drained in order to memory. Reads and fences are ordered against the buffered writes. Reads may optionally be forwarded from or bypass the FIFO (see Configuration).

## Interface
Parameters:
- `sbuf_depth`, default 2: log2 of the FIFO entry count (4 entries). Each entry holds addr[31:0], wdata[31:0] and wstrb[3:0].

Ports (mem_in_type / mem_out_type from `wires`):
- `rst`  in  1  reset, synchronous, active-high.
- `clk`  in  1  single clock, rising edge.
- `sbuf_in`  in  mem_in_type  request from the dtim controller (`dmem_in`).
- `sbuf_out`  out  mem_out_type  response to the dtim controller (`dmem_out`).
- `mem_out`  in  mem_out_type  response from the memory bus.
- `mem_in`  out  mem_in_type  request to the memory bus. `mem_instr` is always 0 and `mem_fence` is always 0.

## Operation
- Request protocol, both sides: the requester holds `mem_valid` and its fields stable until a single-cycle `mem_ready`. A new request may start the cycle after `mem_ready`. At most one request is outstanding per side.
- State machine: IDLE, ACK, RDRAIN, READ, RESP, FDRAIN.
- IDLE, write (`mem_valid`=1, `mem_fence`=0, `|wstrb`=1):
  - If count < 2**sbuf_depth: push the entry, go to ACK.
  - Otherwise stall in IDLE. The request stays held.
- ACK: drive `sbuf_out.mem_ready`=1 and `mem_rdata`=0. The request is masked this cycle so the still-held valid is not pushed twice. Return to IDLE.
- IDLE, read (`|wstrb`=0): go to RDRAIN.
  - RDRAIN waits until count==0, then goes to READ.
  - READ issues the read on `mem_in`. On `mem_out.mem_ready` it captures `mem_rdata` and goes to RESP.
  - RESP drives `sbuf_out.mem_ready`=1 with the captured data, then goes to IDLE.
- IDLE, fence (`mem_fence`=1): go to FDRAIN. When count==0, pulse `mem_ready` with rdata=0 (through RESP), then go to IDLE.
- Drain engine (independent of the FSM):
  - When count>0 and the memory port is not owned by READ, drive the head entry on `mem_in` with `mem_valid`=1.
  - On `mem_out.mem_ready`, pop the head. The next entry is presented the following cycle.
  - Once a drain transaction has started, it owns the port until its ready. READ waits for it.
- Simultaneous push and pop: both take effect; count is unchanged.
- Pointers are sbuf_depth bits wide and wrap modulo the depth. Count is sbuf_depth+1 bits wide. Full means count==2**sbuf_depth; empty means count==0.

## Timing
- Reset values: all `sbuf_out` and `mem_in` fields are 0; count, pointers and FSM are 0 / IDLE. Any buffered or in-flight write is discarded, and `mem_in.mem_valid` is 0 from the first cycle after the reset edge.
- Every output is registered.
- Write acknowledge: `sbuf_out.mem_ready` one cycle after the accepting edge (latency 1) when the FIFO is not full. When full, the acknowledge comes one cycle after the first pop-free slot.
- Read latency: drain time + memory latency + 1 (RESP cycle).
- Drain: the head appears on `mem_in` the cycle after the push, or the cycle after the previous pop. Throughput is one entry per memory ready.
- A `mem_out.mem_ready` arriving while `mem_in.mem_valid`=0 is ignored.

## Configuration
- `SBUF_FWD_EN` defined:
  - A read whose addr[31:2] matches no FIFO entry skips RDRAIN and enters READ immediately. It still waits for any drain transaction already in flight.
  - A read matching an entry whose newest match has wstrb==4'hF is answered from that entry with no memory access: ACK-style response with `mem_rdata`=entry data, latency 1.
  - A read with a partial-strobe match takes RDRAIN.
- `SBUF_FWD_EN` undefined: every read drains the FIFO completely first, and no address comparators are built.

## Test plan
- Single write addr=0x1000_0010, wdata=0xDEADBEEF, wstrb=0xF from IDLE, memory ready after 3 cycles: `sbuf_out.mem_ready` is seen 1 cycle after acceptance. `mem_in` carries the same addr/data/strb until the memory ready, then `mem_valid`=0.
- Five back-to-back writes (depth 4), memory ready after 10 cycles: four ACKs at latency 1. The fifth write stalls until the first pop and is ACKed 1 cycle after it. Memory receives the writes in issue order.
- Write 0x11223344 to 0x2000, then read 0x2000, without `SBUF_FWD_EN`: the read reaches `mem_in` only after the write's memory ready, and the read returns the memory data.
- With `SBUF_FWD_EN`, buffered full-word write 0xCAFEF00D to 0x3000, then read 0x3000: rdata=0xCAFEF00D and ready 1 cycle after acceptance, with no memory read issued. A read of 0x3004 is issued to memory before the drain completes.
- Fence with 3 buffered writes: ready with rdata=0 only after the 3rd memory ready, plus 1 cycle.
- `rst`=1 asserted mid-drain with 2 entries buffered: the next cycle `mem_in.mem_valid`=0 and count=0. A write after reset is accepted normally with ACK latency 1.
